// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings for the accumulator processor control unit
package control_pkg;

    localparam logic [3:0] OP_ADDI = 4'h0;
    localparam logic [3:0] OP_ANDI = 4'h1;
    localparam logic [3:0] OP_ORI  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_BEQZ = 4'h6;
    localparam logic [3:0] OP_J    = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_BR,
        CLS_JMP,
        CLS_HALT,
        CLS_ILL
    } class_e;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_AND    = 2'd1;
    localparam logic [1:0] ALU_OR     = 2'd2;
    localparam logic [1:0] ALU_PASS_B = 2'd3;

    localparam logic [1:0] PC_SRC_INC  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational opcode decoder: class, extension and ALU op
module control_decode
    import control_pkg::*;
(
    input  logic [3:0] opcode_i,
    output class_e     cls_o,
    output logic       ext_sel_o,
    output logic [1:0] alu_op_o
);

    always_comb begin
        cls_o     = CLS_ILL;
        ext_sel_o = EXT_ZERO;
        alu_op_o  = ALU_ADD;
        case (opcode_i)
            OP_ADDI: begin
                cls_o     = CLS_ALU;
                ext_sel_o = EXT_SIGN;
                alu_op_o  = ALU_ADD;
            end
            OP_ANDI: begin
                cls_o    = CLS_ALU;
                alu_op_o = ALU_AND;
            end
            OP_ORI: begin
                cls_o    = CLS_ALU;
                alu_op_o = ALU_OR;
            end
            OP_LDI: begin
                cls_o    = CLS_ALU;
                alu_op_o = ALU_PASS_B;
            end
            OP_LW, OP_SW: cls_o = CLS_MEM;
            OP_BEQZ: begin
                cls_o     = CLS_BR;
                ext_sel_o = EXT_SIGN;
            end
            OP_J:    cls_o = CLS_JMP;
            OP_HALT: cls_o = CLS_HALT;
            default: cls_o = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/accumulator_control_fsm.sv
// rtl/accumulator_control_fsm.sv - multicycle control FSM for the 16-bit accumulator core
module accumulator_control_fsm
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic       Mem_Ready,
    input  logic       Acc_Zero,
    output logic       PC_Write,
    output logic [1:0] PC_Src,
    output logic       IR_Write,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic       Mem_Addr_Sel,
    output logic       Ext_Sel,
    output logic [1:0] ALU_Op,
    output logic       Acc_Write,
    output logic       Acc_Src,
    output logic       Halted,
    output logic       Illegal,
    output logic       Bus_Error
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              bus_err_q, bus_err_d;

    class_e     dec_cls;
    logic       dec_ext;
    logic [1:0] dec_alu;
    logic       mem_wait;

    control_decode u_decode (
        .opcode_i  (Opcode),
        .cls_o     (dec_cls),
        .ext_sel_o (dec_ext),
        .alu_op_o  (dec_alu)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        bus_err_d    = bus_err_q;
        PC_Write     = 1'b0;
        PC_Src       = PC_SRC_INC;
        IR_Write     = 1'b0;
        Mem_Read     = 1'b0;
        Mem_Write    = 1'b0;
        Mem_Addr_Sel = 1'b0;
        Ext_Sel      = EXT_ZERO;
        ALU_Op       = ALU_ADD;
        Acc_Write    = 1'b0;
        Acc_Src      = 1'b0;
        Illegal      = 1'b0;
        Halted       = 1'b0;
        Bus_Error    = bus_err_q;
        mem_wait     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                Mem_Read = 1'b1;
                if (Mem_Ready) begin
                    IR_Write = 1'b1;
                    PC_Write = 1'b1;
                    state_d  = ST_DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            ST_DECODE: begin
                Ext_Sel = dec_ext;
                ALU_Op  = dec_alu;
                case (dec_cls)
                    CLS_ALU, CLS_BR, CLS_JMP: state_d = ST_EXEC;
                    CLS_MEM:                  state_d = ST_MEM;
                    CLS_HALT:                 state_d = ST_HALT;
                    default: begin
                        Illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC: begin
                Ext_Sel = dec_ext;
                ALU_Op  = dec_alu;
                case (dec_cls)
                    CLS_ALU: Acc_Write = 1'b1;
                    CLS_BR: begin
                        PC_Write = Acc_Zero;
                        PC_Src   = PC_SRC_BR;
                    end
                    CLS_JMP: begin
                        PC_Write = 1'b1;
                        PC_Src   = PC_SRC_JUMP;
                    end
                    default: ;
                endcase
                state_d = ST_FETCH;
            end
            ST_MEM: begin
                Mem_Addr_Sel = 1'b1;
                Ext_Sel      = dec_ext;
                ALU_Op       = dec_alu;
                if (Opcode == OP_SW) Mem_Write = 1'b1;
                else                 Mem_Read  = 1'b1;
                if (Mem_Ready) begin
                    if (Opcode != OP_SW) begin
                        Acc_Write = 1'b1;
                        Acc_Src   = 1'b1;
                    end
                    state_d = ST_FETCH;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            ST_HALT: Halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase

        // A ready in the limit cycle never reaches here, so the transfer wins over the timeout.
        if (mem_wait) begin
            if (wait_q == WAIT_LIMIT) begin
                state_d   = ST_HALT;
                bus_err_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        if (Reset) begin
            PC_Write     = 1'b0;
            PC_Src       = PC_SRC_INC;
            IR_Write     = 1'b0;
            Mem_Read     = 1'b0;
            Mem_Write    = 1'b0;
            Mem_Addr_Sel = 1'b0;
            Ext_Sel      = EXT_ZERO;
            ALU_Op       = ALU_ADD;
            Acc_Write    = 1'b0;
            Acc_Src      = 1'b0;
            Illegal      = 1'b0;
            Halted       = 1'b0;
            Bus_Error    = 1'b0;
        end
    end

endmodule
